dump_tx_ctrl: RTL and testbench
===============================

Name: dump_tx_ctrl

Overview:
- Sequences transfer of one captured camera frame from the frame buffer's read port to the rsio_01a UART transmitter.
- Wraps the frame as: header, length, payload, checksum.
- Sits between the capture buffer (read side, RS clock domain) and rsio_01a's TxStart/TxData/TxStatus handshake.
- Issues one byte per UART completion and never overruns the transmitter.

Parameters:
- ADDR_W, 15, buffer address width; maximum frame is 2^ADDR_W-1 bytes.
- HDR0, 8'hA5, first sync byte.
- HDR1, 8'h5A, second sync byte.
- BUSY_TMO, 15, cycles to wait for tx_status to rise after tx_start before treating the byte as sent.

Ports:
- rs_clk  in  1  UART-side clock; all logic on rising edge.
- rs_reset_n  in  1  synchronous, active-low reset.
- frame_valid  in  1  buffer holds a complete frame.
- frame_len  in  ADDR_W  payload byte count; sampled when a dump is accepted.
- dump_req  in  1  request to dump; level or pulse.
- dump_busy  out  1  high from accept until DONE completes.
- dump_done  out  1  one-cycle pulse at end of frame.
- frame_release  out  1  one-cycle pulse, coincident with dump_done; buffer may be refilled.
- tmo_err  out  1  sticky; set when any BUSY_TMO expiry occurs; cleared on accept of the next dump.
- buf_rd_en  out  1  read strobe to buffer.
- buf_rd_addr  out  ADDR_W  read address.
- buf_rd_data  in  8  read data, valid exactly 1 cycle after buf_rd_en.
- tx_start  out  1  one-cycle pulse to rsio_01a TxStart.
- tx_data  out  8  byte for rsio_01a TxData; held stable from tx_start until the byte completes.
- tx_status  in  1  rsio_01a TxStatus; 1 = transmitter busy.

Behaviour:
- Reset: all outputs 0, tmo_err 0, FSM in IDLE, checksum 0, address 0. Reset mid-frame aborts immediately with no dump_done or frame_release.
- Accept: in IDLE, when dump_req && frame_valid && !tx_status:
  - latch frame_len into len_r;
  - clear checksum, address and tmo_err;
  - assert dump_busy the next cycle;
  - go to HDR0.
- dump_req without frame_valid is ignored, not queued.
- Main FSM byte order:
  - HDR0 (HDR0), HDR1 (HDR1);
  - LENH = len_r[15:8], LENL = len_r[7:0], zero-extended to 16 bits;
  - FETCH/DATA repeated len_r times;
  - CSUM (8-bit sum mod 256 of payload bytes only);
  - DONE.
- len_r == 0: LENL goes directly to CSUM, sending byte 00; no buffer reads.
- FETCH: buf_rd_en=1 with buf_rd_addr=addr for exactly one cycle. Next cycle captures buf_rd_data, adds it to checksum and sends it. addr increments after capture.
- Per-byte send (byte sender):
  - ISSUE: tx_start=1 for one cycle, tx_data loaded.
  - WAIT_BUSY: wait for tx_status=1. If BUSY_TMO cycles elapse without it, set tmo_err and complete the byte.
  - WAIT_IDLE: wait for tx_status=0, then signal done to the main FSM.
- Minimum spacing from one tx_start to the next is 3 cycles.
- The next byte's ISSUE occurs no earlier than the cycle after WAIT_IDLE exits. For payload bytes, FETCH may overlap WAIT_IDLE: at most one prefetched byte is held.
- DONE: dump_done=1 and frame_release=1 for one cycle, dump_busy drops the same cycle, return to IDLE.
- A new dump_req during busy is ignored. A new accept is possible the cycle after DONE.
- Maximum length wrap: len_r=2^ADDR_W-1 reads addresses 0..len_r-1; addr never wraps within a frame.
- frame_valid deasserting mid-frame has no effect; the frame completes.

Decomposition:
- Package dump_pkg holds:
  - main FSM state encoding (IDLE, HDR0, HDR1, LENH, LENL, FETCH, DATA, CSUM, DONE);
  - byte-sender state encoding (S_IDLE, ISSUE, WAIT_BUSY, WAIT_IDLE);
  - default HDR0/HDR1 and BUSY_TMO constants.
- One sub-module, rs_byte_sender: send/byte in, done/tmo out, owns tx_start, tx_data and the timeout counter. The main FSM stays in dump_tx_ctrl.

Test Plan:
- UART model busy 10 cycles per byte starting 1 cycle after tx_start; frame_len=4, buffer {01,02,03,04}, pulse dump_req -> tx bytes A5 5A 00 04 01 02 03 04 0A, then one dump_done and one frame_release pulse; tmo_err=0.
- frame_len=0 -> bytes A5 5A 00 00 00; buf_rd_en never asserted.
- Buffer {FF,FF,03}, len 3 -> checksum byte 01 (mod-256 wrap); buf_rd_addr sequence 0,1,2, each with exactly one rd_en cycle.
- UART model never asserts tx_status -> each byte completes after 15 wait cycles, tmo_err=1 after the first byte, 9 tx_start pulses for len 4; next accept clears tmo_err.
- rs_reset_n low for 1 cycle during payload byte 2 -> all outputs 0 the next cycle, no dump_done; a fresh dump_req restarts at HDR0 with addr 0.
- dump_req held high with frame_valid=0 -> no activity. Second dump_req mid-frame -> ignored; exactly one frame sent.

Source files
------------

// File: rtl/dump_pkg.sv
// Shared encodings and defaults for the frame-dump transmit path.
package dump_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_HDR0,
    ST_HDR1,
    ST_LENH,
    ST_LENL,
    ST_FETCH,
    ST_DATA,
    ST_CSUM,
    ST_DONE
  } main_st_e;

  typedef enum logic [1:0] {
    S_IDLE,
    ISSUE,
    WAIT_BUSY,
    WAIT_IDLE
  } snd_st_e;

  localparam logic [7:0] DEF_HDR0     = 8'hA5;
  localparam logic [7:0] DEF_HDR1     = 8'h5A;
  localparam int         DEF_BUSY_TMO = 15;

endpackage

// File: rtl/dump_tx_ctrl_if.sv
// Buffer read port plus rsio_01a transmit handshake.
interface dump_tx_ctrl_if #(parameter int ADDR_W = 15);
  logic              buf_rd_en;
  logic [ADDR_W-1:0] buf_rd_addr;
  logic [7:0]        buf_rd_data;
  logic              tx_start;
  logic [7:0]        tx_data;
  logic              tx_status;

  modport master (
    output buf_rd_en, buf_rd_addr, tx_start, tx_data,
    input  buf_rd_data, tx_status
  );

  modport slave (
    input  buf_rd_en, buf_rd_addr, tx_start, tx_data,
    output buf_rd_data, tx_status
  );
endinterface

// File: rtl/rs_byte_sender.sv
// Hands one byte to rsio_01a and reports completion; a transmitter that never
// goes busy is tolerated by timing out and treating the byte as sent.
module rs_byte_sender
  import dump_pkg::*;
#(
  parameter int BUSY_TMO = DEF_BUSY_TMO
) (
  input  logic       rs_clk,
  input  logic       rs_reset_n,
  input  logic       send,
  input  logic [7:0] tx_byte,
  output logic       done,
  output logic       tmo,
  output logic       tx_start,
  output logic [7:0] tx_data,
  input  logic       tx_status
);

  localparam int CW = $clog2(BUSY_TMO + 1);

  snd_st_e       st;
  logic [CW-1:0] cnt;

  always_ff @(posedge rs_clk) begin
    if (!rs_reset_n) begin
      st       <= S_IDLE;
      cnt      <= '0;
      done     <= 1'b0;
      tmo      <= 1'b0;
      tx_start <= 1'b0;
      tx_data  <= 8'h00;
    end else begin
      done     <= 1'b0;
      tmo      <= 1'b0;
      tx_start <= 1'b0;
      case (st)
        S_IDLE: if (send) begin
          tx_data  <= tx_byte;
          tx_start <= 1'b1;
          st       <= ISSUE;
        end
        ISSUE: begin
          cnt <= '0;
          st  <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (tx_status) begin
            st <= WAIT_IDLE;
          end else if (cnt == CW'(BUSY_TMO - 1)) begin
            // transmitter never acknowledged: count the byte as gone
            tmo  <= 1'b1;
            done <= 1'b1;
            st   <= S_IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        WAIT_IDLE: if (!tx_status) begin
          done <= 1'b1;
          st   <= S_IDLE;
        end
        default: st <= S_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/dump_tx_ctrl.sv
// Frame dump sequencer: header, 16-bit length, payload, mod-256 checksum,
// one byte per UART completion.
module dump_tx_ctrl
  import dump_pkg::*;
#(
  parameter int         ADDR_W   = 15,
  parameter logic [7:0] HDR0     = DEF_HDR0,
  parameter logic [7:0] HDR1     = DEF_HDR1,
  parameter int         BUSY_TMO = DEF_BUSY_TMO
) (
  input  logic              rs_clk,
  input  logic              rs_reset_n,
  input  logic              frame_valid,
  input  logic [ADDR_W-1:0] frame_len,
  input  logic              dump_req,
  output logic              dump_busy,
  output logic              dump_done,
  output logic              frame_release,
  output logic              tmo_err,
  dump_tx_ctrl_if.master    bus
);

  main_st_e          st, nxt;
  logic [ADDR_W-1:0] len_r, addr;
  logic [15:0]       len16;
  logic [7:0]        csum, tx_byte, cur_byte;
  logic              send, pend, rd_en, snd_done, snd_tmo;

  assign len16           = 16'(len_r);
  assign bus.buf_rd_en   = rd_en;
  assign bus.buf_rd_addr = addr;

  // Byte to send and the state that follows, for every byte-emitting state.
  always_comb begin
    cur_byte = 8'h00;
    nxt      = ST_IDLE;
    case (st)
      ST_HDR0: begin cur_byte = HDR0;        nxt = ST_HDR1; end
      ST_HDR1: begin cur_byte = HDR1;        nxt = ST_LENH; end
      ST_LENH: begin cur_byte = len16[15:8]; nxt = ST_LENL; end
      ST_LENL: begin
        cur_byte = len16[7:0];
        nxt      = (len_r == '0) ? ST_CSUM : ST_FETCH;
      end
      ST_DATA: begin
        cur_byte = bus.buf_rd_data;
        nxt      = (addr == len_r) ? ST_CSUM : ST_FETCH;
      end
      ST_CSUM: begin cur_byte = csum;        nxt = ST_DONE; end
      default: ;
    endcase
  end

  always_ff @(posedge rs_clk) begin
    if (!rs_reset_n) begin
      st            <= ST_IDLE;
      len_r         <= '0;
      addr          <= '0;
      csum          <= 8'h00;
      tx_byte       <= 8'h00;
      send          <= 1'b0;
      pend          <= 1'b0;
      rd_en         <= 1'b0;
      dump_busy     <= 1'b0;
      dump_done     <= 1'b0;
      frame_release <= 1'b0;
      tmo_err       <= 1'b0;
    end else begin
      send          <= 1'b0;
      rd_en         <= 1'b0;
      dump_done     <= 1'b0;
      frame_release <= 1'b0;
      if (snd_tmo) tmo_err <= 1'b1;
      case (st)
        ST_IDLE: if (dump_req && frame_valid && !bus.tx_status) begin
          len_r     <= frame_len;
          addr      <= '0;
          csum      <= 8'h00;
          tmo_err   <= 1'b0;
          pend      <= 1'b0;
          dump_busy <= 1'b1;
          st        <= ST_HDR0;
        end
        ST_HDR0, ST_HDR1, ST_LENH, ST_LENL, ST_DATA, ST_CSUM: begin
          if (!pend) begin
            // first cycle of DATA is the cycle read data is valid
            send    <= 1'b1;
            tx_byte <= cur_byte;
            pend    <= 1'b1;
            if (st == ST_DATA) begin
              csum <= csum + cur_byte;
              addr <= addr + ADDR_W'(1);
            end
          end else if (snd_done) begin
            pend <= 1'b0;
            st   <= nxt;
            if (nxt == ST_FETCH) rd_en <= 1'b1;
            if (nxt == ST_DONE) begin
              dump_done     <= 1'b1;
              frame_release <= 1'b1;
              dump_busy     <= 1'b0;
            end
          end
        end
        ST_FETCH: st <= ST_DATA;
        ST_DONE:  st <= ST_IDLE;
        default:  st <= ST_IDLE;
      endcase
    end
  end

  rs_byte_sender #(.BUSY_TMO(BUSY_TMO)) u_sender (
    .rs_clk     (rs_clk),
    .rs_reset_n (rs_reset_n),
    .send       (send),
    .tx_byte    (tx_byte),
    .done       (snd_done),
    .tmo        (snd_tmo),
    .tx_start   (bus.tx_start),
    .tx_data    (bus.tx_data),
    .tx_status  (bus.tx_status)
  );

endmodule

// File: tb/tb_dump_tx_ctrl.sv
// Directed bench for dump_tx_ctrl with a behavioural UART and frame buffer.
module tb_dump_tx_ctrl;
  import dump_pkg::*;

  localparam int AW = 15;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          frame_valid, dump_req;
  logic [AW-1:0] frame_len;
  logic          dump_busy, dump_done, frame_release, tmo_err;

  always #5 clk = ~clk;

  dump_tx_ctrl_if #(.ADDR_W(AW)) bus ();

  dump_tx_ctrl #(.ADDR_W(AW)) dut (
    .rs_clk        (clk),
    .rs_reset_n    (rst_n),
    .frame_valid   (frame_valid),
    .frame_len     (frame_len),
    .dump_req      (dump_req),
    .dump_busy     (dump_busy),
    .dump_done     (dump_done),
    .frame_release (frame_release),
    .tmo_err       (tmo_err),
    .bus           (bus)
  );

  // UART busy for 10 cycles starting the cycle after tx_start; buffer has 1-cycle read latency
  logic [7:0] mem [0:15];
  logic       uart_dead = 1'b0;
  int         ucnt = 0;

  always @(posedge clk) begin
    if (bus.buf_rd_en) bus.buf_rd_data <= mem[bus.buf_rd_addr[3:0]];
    if (bus.tx_start && !uart_dead) ucnt <= 10;
    else if (ucnt > 0)              ucnt <= ucnt - 1;
  end
  assign bus.tx_status = (ucnt > 0);

  logic [7:0]    txq[$];
  logic [AW-1:0] rdq[$];
  logic [7:0]    cur = 8'h00;
  logic          tmo_at2;
  int done_cnt, rel_cnt, rd_cnt, busy_cnt, hold_err, coinc_err;
  int min_gap, max_gap, cyc = 0, last_start = 0;

  always @(negedge clk) begin
    cyc++;
    if (bus.tx_start) begin
      if (txq.size() > 0) begin
        if (cyc - last_start < min_gap) min_gap = cyc - last_start;
        if (cyc - last_start > max_gap) max_gap = cyc - last_start;
      end
      last_start = cyc;
      if (txq.size() == 1) tmo_at2 = tmo_err;
      txq.push_back(bus.tx_data);
      cur = bus.tx_data;
    end else if (dump_busy && txq.size() > 0 && bus.tx_data !== cur) begin
      hold_err++;
    end
    if (dump_done)     done_cnt++;
    if (frame_release) rel_cnt++;
    if (dump_done !== frame_release) coinc_err++;
    if (bus.buf_rd_en) begin rd_cnt++; rdq.push_back(bus.buf_rd_addr); end
    if (dump_busy) busy_cnt++;
  end

  int total = 0, bad = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic clr();
    txq.delete(); rdq.delete();
    done_cnt = 0; rel_cnt = 0; rd_cnt = 0; busy_cnt = 0;
    hold_err = 0; coinc_err = 0; min_gap = 1000; max_gap = 0; tmo_at2 = 1'b0;
  endtask

  task automatic pulse_req();
    @(negedge clk) dump_req = 1'b1;
    @(negedge clk) dump_req = 1'b0;
  endtask

  task automatic wait_done(input int max);
    int n = 0;
    while (done_cnt == 0 && n < max) begin @(negedge clk); n++; end
    chk("done_seen", (done_cnt > 0) ? 1 : 0, 1);
    repeat (5) @(negedge clk);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_busy"},    dump_busy,       0);
    chk({tag, "_done"},    dump_done,       0);
    chk({tag, "_rel"},     frame_release,   0);
    chk({tag, "_tmo"},     tmo_err,         0);
    chk({tag, "_start"},   bus.tx_start,    0);
    chk({tag, "_data"},    bus.tx_data,     0);
    chk({tag, "_rd_en"},   bus.buf_rd_en,   0);
    chk({tag, "_rd_addr"}, bus.buf_rd_addr, 0);
  endtask

  function automatic int qbyte(input int i);
    return (i < txq.size()) ? int'(txq[i]) : -1;
  endfunction

  typedef struct packed {
    logic [AW-1:0]   len;
    logic [0:3][7:0] d;
    logic            dead;
    logic [3:0]      nb;
    logic [0:8][7:0] exp;
    logic            tmo;
  } vec_t;

  vec_t vecs [6];

  initial begin
    vecs[0] = '{15'd4, {8'h01, 8'h02, 8'h03, 8'h04}, 1'b0, 4'd9,
                {8'hA5, 8'h5A, 8'h00, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0A}, 1'b0};
    vecs[1] = '{15'd0, {8'h00, 8'h00, 8'h00, 8'h00}, 1'b0, 4'd5,
                {8'hA5, 8'h5A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 1'b0};
    vecs[2] = '{15'd3, {8'hFF, 8'hFF, 8'h03, 8'h00}, 1'b0, 4'd8,
                {8'hA5, 8'h5A, 8'h00, 8'h03, 8'hFF, 8'hFF, 8'h03, 8'h01, 8'h00}, 1'b0};
    vecs[3] = '{15'd4, {8'h01, 8'h02, 8'h03, 8'h04}, 1'b1, 4'd9,
                {8'hA5, 8'h5A, 8'h00, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0A}, 1'b1};
    vecs[4] = '{15'd2, {8'h10, 8'h20, 8'h00, 8'h00}, 1'b0, 4'd7,
                {8'hA5, 8'h5A, 8'h00, 8'h02, 8'h10, 8'h20, 8'h30, 8'h00, 8'h00}, 1'b0};
    vecs[5] = '{15'd1, {8'h80, 8'h00, 8'h00, 8'h00}, 1'b0, 4'd6,
                {8'hA5, 8'h5A, 8'h00, 8'h01, 8'h80, 8'h80, 8'h00, 8'h00, 8'h00}, 1'b0};

    rst_n = 1'b0; dump_req = 1'b0; frame_valid = 1'b0; frame_len = '0;
    for (int i = 0; i < 16; i++) mem[i] = 8'(i);
    clr();
    repeat (3) @(negedge clk);
    chk_idle_outputs("reset");
    rst_n = 1'b1;

    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < 4; i++) mem[i] = vecs[k].d[i];
      uart_dead   = vecs[k].dead;
      frame_len   = vecs[k].len;
      frame_valid = 1'b1;
      clr();
      pulse_req();
      wait_done(600);
      chk($sformatf("v%0d_nbytes", k), txq.size(), int'(vecs[k].nb));
      for (int i = 0; i < int'(vecs[k].nb); i++)
        chk($sformatf("v%0d_byte%0d", k, i), qbyte(i), int'(vecs[k].exp[i]));
      chk($sformatf("v%0d_done_cnt", k), done_cnt, 1);
      chk($sformatf("v%0d_rel_cnt", k), rel_cnt, 1);
      chk($sformatf("v%0d_done_rel_coinc", k), coinc_err, 0);
      chk($sformatf("v%0d_rd_cnt", k), rd_cnt, int'(vecs[k].len));
      for (int i = 0; i < rdq.size(); i++)
        chk($sformatf("v%0d_rd_addr%0d", k, i), int'(rdq[i]), i);
      chk($sformatf("v%0d_tmo_err", k), tmo_err, int'(vecs[k].tmo));
      chk($sformatf("v%0d_busy_after", k), dump_busy, 0);
      chk($sformatf("v%0d_data_hold", k), hold_err, 0);
      chk($sformatf("v%0d_gap_ge3", k), (min_gap >= 3) ? 1 : 0, 1);
      if (vecs[k].dead) begin
        chk($sformatf("v%0d_tmo_after_first", k), tmo_at2, 1);
        chk($sformatf("v%0d_tmo_gap_min", k), (min_gap >= 16) ? 1 : 0, 1);
        chk($sformatf("v%0d_tmo_gap_max", k), (max_gap <= 24) ? 1 : 0, 1);
      end
    end
    uart_dead = 1'b0;

    // Long frame: nonzero high length byte, checksum over addr[3:0] pattern
    for (int i = 0; i < 16; i++) mem[i] = 8'(i);
    frame_len = 15'd261;
    clr();
    pulse_req();
    wait_done(8000);
    chk("long_nbytes", txq.size(), 266);
    chk("long_lenh", qbyte(2), 8'h01);
    chk("long_lenl", qbyte(3), 8'h05);
    chk("long_csum", qbyte(265), 8'h8A);
    chk("long_rd_cnt", rd_cnt, 261);
    chk("long_last_addr", (rdq.size() == 261) ? int'(rdq[260]) : -1, 260);

    // Request without a valid frame is dropped
    clr();
    frame_valid = 1'b0;
    @(negedge clk) dump_req = 1'b1;
    repeat (30) @(negedge clk);
    dump_req = 1'b0;
    repeat (5) @(negedge clk);
    chk("novalid_busy", busy_cnt, 0);
    chk("novalid_tx", txq.size(), 0);
    chk("novalid_rd", rd_cnt, 0);

    // Second request mid-frame ignored; frame_valid dropping mid-frame harmless
    for (int i = 0; i < 4; i++) mem[i] = vecs[0].d[i];
    frame_len = 15'd4; frame_valid = 1'b1;
    clr();
    pulse_req();
    begin
      int n = 0;
      while (txq.size() < 3 && n < 300) begin @(negedge clk); n++; end
    end
    pulse_req();
    frame_valid = 1'b0;
    wait_done(600);
    repeat (100) @(negedge clk);
    chk("dup_nbytes", txq.size(), 9);
    chk("dup_done_cnt", done_cnt, 1);
    chk("dup_csum", qbyte(8), 8'h0A);

    // Reset during payload byte 2 aborts the frame
    frame_valid = 1'b1;
    clr();
    pulse_req();
    begin
      int n = 0;
      while (txq.size() < 6 && n < 400) begin @(negedge clk); n++; end
      chk("rst_reach_byte2", txq.size(), 6);
    end
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk);
    chk_idle_outputs("midrst");
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("midrst_no_done", done_cnt, 0);
    chk("midrst_no_rel", rel_cnt, 0);
    begin
      int n = 0;
      while (bus.tx_status && n < 30) begin @(negedge clk); n++; end
    end
    clr();
    pulse_req();
    wait_done(600);
    chk("restart_nbytes", txq.size(), 9);
    for (int i = 0; i < 9; i++)
      chk($sformatf("restart_byte%0d", i), qbyte(i), int'(vecs[0].exp[i]));
    chk("restart_addr0", (rdq.size() > 0) ? int'(rdq[0]) : -1, 0);
    chk("restart_done_cnt", done_cnt, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
